// File: rtl/param_stack_pkg.sv
// Shared types and helpers for the param_stack LIFO: the decoded per-cycle operation
// and the count-width helper used to size the occupancy counter.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_SWAP = 2'd3
    } stack_op_t;

    // Bits needed to hold an occupancy value of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/param_stack_ram.sv
// Storage array for param_stack: one synchronous write port and one asynchronous read
// port. The contents are deliberately left unreset.
module stack_ram #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with swap-top, registered pop output, occupancy flags and
// sticky error flags. Optional Max_Count watermark port via PARAM_STACK_WATERMARK_EN.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6,
    localparam int CW       = count_width(DEPTH)
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             Clr,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Push,
    input  logic             Pop,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Out_Valid,
    output logic [WIDTH-1:0] Top,
    output logic [CW-1:0]    Count,
    output logic             Full,
    output logic             Empty,
    output logic             Almost_Full,
    output logic             Overflow,
    output logic             Underflow
`ifdef PARAM_STACK_WATERMARK_EN
    ,
    output logic [CW-1:0]    Max_Count
`endif
);

    localparam int AW = $clog2(DEPTH);

    stack_op_t        op_s;
    logic [CW-1:0]    count_r, count_nxt_s, count_m1_s;
    logic [WIDTH-1:0] dout_r, dout_nxt_s;
    logic             valid_r, valid_nxt_s;
    logic             ovf_r, ovf_nxt_s;
    logic             unf_r, unf_nxt_s;
    logic             full_s, empty_s;
    logic             we_s;
    logic [AW-1:0]    waddr_s, top_addr_s;
    logic [WIDTH-1:0] rd_data_s;

    assign full_s     = (count_r == CW'(DEPTH));
    assign empty_s    = (count_r == {CW{1'b0}});
    assign count_m1_s = count_r - CW'(1);
    // Hold the read address at 0 when empty so it never leaves the array range.
    assign top_addr_s = empty_s ? {AW{1'b0}} : count_m1_s[AW-1:0];

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .Clk     (Clk),
        .wr_en   (we_s),
        .wr_addr (waddr_s),
        .wr_data (Data_In),
        .rd_addr (top_addr_s),
        .rd_data (rd_data_s)
    );

    // Decode the request pair into a single operation
    always_comb begin
        op_s = OP_IDLE;
        case ({Push, Pop})
            2'b10:   op_s = OP_PUSH;
            2'b01:   op_s = OP_POP;
            2'b11:   op_s = OP_SWAP;
            default: op_s = OP_IDLE;
        endcase
    end

    // Next-state for count, output word, flags and the RAM write port
    always_comb begin
        count_nxt_s = count_r;
        dout_nxt_s  = dout_r;
        valid_nxt_s = 1'b0;
        ovf_nxt_s   = ovf_r;
        unf_nxt_s   = unf_r;
        we_s        = 1'b0;
        waddr_s     = count_r[AW-1:0];
        if (Clr) begin
            count_nxt_s = {CW{1'b0}};
            ovf_nxt_s   = 1'b0;
            unf_nxt_s   = 1'b0;
        end else begin
            case (op_s)
                OP_PUSH: begin
                    if (full_s) begin
                        ovf_nxt_s = 1'b1;
                    end else begin
                        we_s        = 1'b1;
                        count_nxt_s = count_r + CW'(1);
                    end
                end
                OP_POP: begin
                    if (empty_s) begin
                        unf_nxt_s = 1'b1;
                    end else begin
                        dout_nxt_s  = rd_data_s;
                        valid_nxt_s = 1'b1;
                        count_nxt_s = count_m1_s;
                    end
                end
                OP_SWAP: begin
                    valid_nxt_s = 1'b1;
                    if (empty_s) begin
                        dout_nxt_s = Data_In;
                    end else begin
                        dout_nxt_s = rd_data_s;
                        we_s       = 1'b1;
                        waddr_s    = top_addr_s;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            count_r <= {CW{1'b0}};
            dout_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            dout_r  <= dout_nxt_s;
            valid_r <= valid_nxt_s;
            ovf_r   <= ovf_nxt_s;
            unf_r   <= unf_nxt_s;
        end
    end

`ifdef PARAM_STACK_WATERMARK_EN
    logic [CW-1:0] max_r, max_nxt_s;

    // Track the highest occupancy seen since reset or clear
    always_comb begin
        if (Clr) begin
            max_nxt_s = {CW{1'b0}};
        end else if (count_nxt_s > max_r) begin
            max_nxt_s = count_nxt_s;
        end else begin
            max_nxt_s = max_r;
        end
    end

    // Watermark register
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            max_r <= {CW{1'b0}};
        end else begin
            max_r <= max_nxt_s;
        end
    end

    assign Max_Count = max_r;
`endif

    assign Data_Out    = dout_r;
    assign Out_Valid   = valid_r;
    assign Count       = count_r;
    assign Full        = full_s;
    assign Empty       = empty_s;
    assign Almost_Full = (count_r >= CW'(AFULL_LVL));
    assign Overflow    = ovf_r;
    assign Underflow   = unf_r;
    assign Top         = empty_s ? {WIDTH{1'b0}} : rd_data_s;

endmodule
